poca_engine_arbiter: RTL and testbench

//  Shares the single crypto-engine bus (TRNG / ECC / Hash, one address/write/data-return channel) between N_REQ requesters: POCA FSM, HSM key path, debug.

---
 rtl/poca_engine_arbiter_pkg.sv | 18 +
 rtl/poca_engine_arbiter_rr_priority_picker.sv | 33 +++
 rtl/poca_engine_arbiter.sv | 161 ++++++++++++++++
 tb/tb_poca_engine_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poca_engine_arbiter_pkg.sv
// Shared state encoding, default burst limit and sizing helper for the engine-bus arbiter.
package poca_engine_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // 256-bit hash/ECC result read back as 32-bit words.
  localparam int POCA_MAX_BEATS = 8;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/poca_engine_arbiter_rr_priority_picker.sv
// Round-robin picker: one-hot of the first set request at or above rr_ptr_i, wrapping.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module poca_engine_arbiter_rr_priority_picker
  import poca_engine_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int PW    = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    rr_ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             any_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = PW'((int'(rr_ptr_i) + off) % N_REQ);
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/poca_engine_arbiter.sv
// Engine-bus arbiter: grants one requester per write(+read-back) transaction; optional watchdog under POCA_ARB_TIMEOUT_EN.
// Latency: req -> gnt 1 clk; engine responses routed combinationally; RELEASE then IDLE after every transaction.
// Backpressure: requests raised while a grant is held wait until the arbiter is back in IDLE.
module poca_engine_arbiter
  import poca_engine_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = POCA_MAX_BEATS
`ifdef POCA_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_rd,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]        req_is_write,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       addr_out,
  output logic                    is_write,
  input  logic                    write_complete,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    data_input_ready,
  input  logic                    input_data_transfer_complete,
  output logic [N_REQ-1:0]        rsp_write_complete,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [N_REQ-1:0]        rsp_done,
  output logic [3:0]              beat_count,
  output logic                    overrun_err,
  output logic                    busy
`ifdef POCA_ARB_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  localparam int PW = ptr_w(N_REQ);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [PW-1:0]    gidx_q, rr_ptr_q, rr_ptr_d, pick_idx;
  logic             rd_needed_q, overrun_q;
  logic [3:0]       beat_q, beat_d;
  logic [N_REQ-1:0] pick;
  logic             any_req, to_hit, granted_held, beat_full, end_txn;

  poca_engine_arbiter_rr_priority_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick),
    .any_o    (any_req)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  assign granted_held = req[gidx_q];
  assign rr_ptr_d     = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign beat_full    = (beat_q == 4'(MAX_BEATS));
  assign beat_d       = beat_full ? beat_q : beat_q + 4'd1;

  // Abort (granted req dropped) and watchdog both win over normal engine progress.
  always_comb begin
    end_txn = 1'b0;
    if (state_q == ST_WRITE)
      end_txn = !granted_held || to_hit || (write_complete && !rd_needed_q);
    else if (state_q == ST_READ)
      end_txn = !granted_held || to_hit || input_data_transfer_complete;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      rd_needed_q <= 1'b0;
      beat_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_q       <= pick;
            gidx_q      <= pick_idx;
            rd_needed_q <= req_rd[pick_idx];
            state_q     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!end_txn && write_complete) state_q <= ST_READ;
        end
        ST_READ: begin
          if (data_input_ready) begin
            beat_q <= beat_d;
            if (beat_full) overrun_q <= 1'b1;
          end
        end
        ST_RELEASE: begin
          beat_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (end_txn) begin
        state_q  <= ST_RELEASE;
        gnt_q    <= '0;
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

`ifdef POCA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;
  logic          timeout_err_q;

  assign to_hit = ((state_q == ST_WRITE) || (state_q == ST_READ)) &&
                  (to_cnt_q == TW'(TIMEOUT - 1));

  // Counter restarts on entry to WRITE (from IDLE/RELEASE), on WRITE->READ and on every beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= to_hit;
      if ((state_q == ST_IDLE) || (state_q == ST_RELEASE) || data_input_ready ||
          ((state_q == ST_WRITE) && write_complete))
        to_cnt_q <= '0;
      else
        to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign to_hit = 1'b0;
`endif

  assign gnt                = gnt_q;
  assign busy               = (state_q != ST_IDLE);
  assign beat_count         = beat_q;
  assign overrun_err        = overrun_q;
  assign addr_out           = (state_q == ST_WRITE) ? req_addr[int'(gidx_q)*ADDR_W +: ADDR_W] : '0;
  assign is_write           = (state_q == ST_WRITE) && req_is_write[gidx_q];
  assign rsp_write_complete = gnt_q & {N_REQ{write_complete}};
  assign rsp_valid          = gnt_q & {N_REQ{data_input_ready}};
  assign rsp_done           = gnt_q & {N_REQ{input_data_transfer_complete}};
  assign rsp_data           = (|gnt_q) ? data_in : '0;

endmodule

// File: tb/tb_poca_engine_arbiter.sv
// Self-checking bench for poca_engine_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin / beat-count model.
module tb_poca_engine_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  req, req_rd, req_is_write;
  logic [23:0] req_addr;
  logic [2:0]  gnt, rsp_write_complete, rsp_valid, rsp_done;
  logic [7:0]  addr_out;
  logic        is_write, write_complete, data_input_ready, input_data_transfer_complete;
  logic [31:0] data_in, rsp_data;
  logic [3:0]  beat_count;
  logic        overrun_err, busy;
`ifdef POCA_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int   vec = 0;
  int   errs = 0;
  int   m_rr = 0;
  logic m_ovr = 1'b0;

  always #5 clk = ~clk;

  poca_engine_arbiter dut (
    .clk(clk), .rstn(rstn), .req(req), .req_rd(req_rd), .req_addr(req_addr),
    .req_is_write(req_is_write), .gnt(gnt), .addr_out(addr_out), .is_write(is_write),
    .write_complete(write_complete), .data_in(data_in), .data_input_ready(data_input_ready),
    .input_data_transfer_complete(input_data_transfer_complete),
    .rsp_write_complete(rsp_write_complete), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_done(rsp_done), .beat_count(beat_count), .overrun_err(overrun_err), .busy(busy)
`ifdef POCA_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; req_rd = '0; req_addr = '0; req_is_write = '0;
    write_complete = 1'b0; data_in = '0; data_input_ready = 1'b0;
    input_data_transfer_complete = 1'b0;
  endtask

  // Round-robin winner: first requester at or after the pointer, wrapping.
  function automatic int pick_model(input logic [2:0] m, input int rr);
    for (int k = 0; k < 3; k++)
      if (m[(rr + k) % 3]) return (rr + k) % 3;
    return -1;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; req = 3'b111; req_rd = 3'b111; req_addr = 24'hFFFFFF; req_is_write = 3'b111;
    write_complete = 1'b1; data_in = 32'hDEADBEEF; data_input_ready = 1'b1;
    input_data_transfer_complete = 1'b1;
    cyc(); cyc();
    vec++; if (gnt !== 3'b000) begin errs++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    vec++; if ({busy, overrun_err, beat_count} !== 6'b0) begin errs++;
      $display("FAIL reset_state: busy/ovr/beats got %b/%b/%0d want 0/0/0", busy, overrun_err, beat_count); end
    vec++; if ({addr_out, is_write} !== 9'b0) begin errs++;
      $display("FAIL reset_bus: addr/wr got %h/%b want 00/0", addr_out, is_write); end
    vec++; if ({rsp_write_complete, rsp_valid, rsp_done} !== 9'b0) begin errs++;
      $display("FAIL reset_rsp: got %b %b %b want zeros", rsp_write_complete, rsp_valid, rsp_done); end
    vec++; if (rsp_data !== 32'h0) begin errs++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    idle_inputs(); cyc(); rstn = 1'b1; cyc();
    vec++; if (busy !== 1'b0 || gnt !== 3'b000) begin errs++;
      $display("FAIL reset_idle: busy/gnt got %b/%b want 0/000", busy, gnt); end
    m_rr = 0; m_ovr = 1'b0;
  endtask

  task automatic test_write_only();
    req = 3'b001; req_rd = 3'b000; req_addr = 24'h0000A5; req_is_write = 3'b001; #1;
    vec++; if (gnt !== 3'b000) begin errs++; $display("FAIL wo_latency: got %b want 000", gnt); end
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 5) write_complete = 1'b1;
      #1;
      vec++; if (gnt !== 3'b001 || addr_out !== 8'hA5 || is_write !== 1'b1) begin errs++;
        $display("FAIL wo_grant c%0d: gnt/addr/wr got %b/%h/%b want 001/a5/1", c, gnt, addr_out, is_write); end
    end
    vec++; if (rsp_write_complete !== 3'b001) begin errs++;
      $display("FAIL wo_wc_route: got %b want 001", rsp_write_complete); end
    cyc(); write_complete = 1'b0; req = 3'b000; #1;
    vec++; if (gnt !== 3'b000 || busy !== 1'b1 || addr_out !== 8'h00) begin errs++;
      $display("FAIL wo_release: gnt/busy/addr got %b/%b/%h want 000/1/00", gnt, busy, addr_out); end
    cyc();
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL wo_idle: busy got %b want 0", busy); end
    m_rr = 1;
  endtask

  task automatic test_hash_read();
    logic [31:0] hv [8];
    hv = '{32'h1F, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
    req = 3'b001; req_rd = 3'b001;
    cyc();
    vec++; if (gnt !== 3'b001) begin errs++; $display("FAIL hr_gnt: got %b want 001", gnt); end
    write_complete = 1'b1;
    cyc(); write_complete = 1'b0;
    for (int b = 0; b < 8; b++) begin
      data_in = hv[b]; data_input_ready = 1'b1; #1;
      vec++; if (rsp_data !== hv[b] || rsp_valid !== 3'b001) begin errs++;
        $display("FAIL hr_beat%0d: data/valid got %h/%b want %h/001", b, rsp_data, rsp_valid, hv[b]); end
      cyc();
    end
    data_input_ready = 1'b0; input_data_transfer_complete = 1'b1; #1;
    vec++; if (rsp_done !== 3'b001 || beat_count !== 4'd8) begin errs++;
      $display("FAIL hr_done: done/beats got %b/%0d want 001/8", rsp_done, beat_count); end
    cyc(); idle_inputs();
    vec++; if (gnt !== 3'b000 || beat_count !== 4'd8 || overrun_err !== 1'b0) begin errs++;
      $display("FAIL hr_release: gnt/beats/ovr got %b/%0d/%b want 000/8/0", gnt, beat_count, overrun_err); end
    cyc();
    vec++; if (beat_count !== 4'd0) begin errs++; $display("FAIL hr_clear: beats got %0d want 0", beat_count); end
    m_rr = 1;
  endtask

  task automatic test_contention();
    logic [2:0] exp [4];
    int gap;
    exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    idle_inputs(); rstn = 1'b0; cyc();
    req = 3'b111; rstn = 1'b1; m_rr = 0; m_ovr = 1'b0;
    gap = 0;
    for (int k = 0; k < 4; k++) begin
      while (gnt === 3'b000 && gap < 8) begin
        cyc();
        if (gnt === 3'b000) gap++;
      end
      vec++; if (gnt !== exp[k]) begin errs++; $display("FAIL ct_gnt%0d: got %b want %b", k, gnt, exp[k]); end
      if (k > 0) begin
        vec++; if (gap != 2) begin errs++; $display("FAIL ct_gap%0d: got %0d want 2", k, gap); end
      end
      write_complete = 1'b1;
      cyc(); write_complete = 1'b0;
      if (k == 3) req = 3'b000;
      gap = (gnt === 3'b000) ? 1 : 0;
    end
    cyc();
    m_rr = 1;
  endtask

  task automatic test_overrun();
    req = 3'b010; req_rd = 3'b010;
    cyc();
    vec++; if (gnt !== 3'b010) begin errs++; $display("FAIL ov_gnt: got %b want 010", gnt); end
    write_complete = 1'b1;
    for (int b = 0; b <= 8; b++) begin
      cyc(); write_complete = 1'b0; #1;
      vec++; if (beat_count !== 4'(b) || overrun_err !== 1'b0) begin errs++;
        $display("FAIL ov_count%0d: beats/ovr got %0d/%b want %0d/0", b, beat_count, overrun_err, b); end
      data_input_ready = 1'b1; data_in = $urandom;
    end
    cyc(); data_input_ready = 1'b0; #1;
    vec++; if (beat_count !== 4'd8 || overrun_err !== 1'b1) begin errs++;
      $display("FAIL ov_ninth: beats/ovr got %0d/%b want 8/1", beat_count, overrun_err); end
    input_data_transfer_complete = 1'b1;
    cyc(); idle_inputs(); cyc();
    req = 3'b100; req_rd = 3'b000;
    cyc(); write_complete = 1'b1;
    cyc(); idle_inputs(); cyc();
    vec++; if (overrun_err !== 1'b1) begin errs++; $display("FAIL ov_sticky: got %b want 1", overrun_err); end
    m_rr = 0; m_ovr = 1'b1;
  endtask

  task automatic test_isolation_abort();
    req = 3'b010; req_rd = 3'b010;
    cyc();
    vec++; if (gnt !== 3'b010) begin errs++; $display("FAIL ab_gnt: got %b want 010", gnt); end
    req = 3'b011; write_complete = 1'b1; data_input_ready = 1'b1; data_in = 32'h55; #1;
    vec++; if (rsp_valid !== 3'b010 || rsp_write_complete !== 3'b010) begin errs++;
      $display("FAIL ab_iso_w: valid/wc got %b/%b want 010/010", rsp_valid, rsp_write_complete); end
    for (int b = 0; b < 2; b++) begin
      cyc(); write_complete = 1'b0; #1;
      vec++; if (rsp_valid !== 3'b010 || busy !== 1'b1) begin errs++;
        $display("FAIL ab_iso_r%0d: valid/busy got %b/%b want 010/1", b, rsp_valid, busy); end
    end
    cyc(); req = 3'b001; #1;
    vec++; if (rsp_valid !== 3'b010) begin errs++; $display("FAIL ab_route: got %b want 010", rsp_valid); end
    cyc(); data_input_ready = 1'b0;
    vec++; if (gnt !== 3'b000 || busy !== 1'b1) begin errs++;
      $display("FAIL ab_release: gnt/busy got %b/%b want 000/1", gnt, busy); end
    cyc(); cyc();
    vec++; if (gnt !== 3'b001) begin errs++; $display("FAIL ab_next: got %b want 001", gnt); end
    write_complete = 1'b1; req_rd = 3'b000;
    cyc(); idle_inputs(); cyc();
    m_rr = 1;
  endtask

  task automatic test_reset_mid_read();
    req = 3'b100; req_rd = 3'b100;
    cyc(); write_complete = 1'b1;
    cyc(); write_complete = 1'b0;
    for (int b = 0; b < 3; b++) begin
      data_input_ready = 1'b1; data_in = $urandom;
      cyc();
    end
    vec++; if (beat_count !== 4'd3 || overrun_err !== 1'b1) begin errs++;
      $display("FAIL rm_pre: beats/ovr got %0d/%b want 3/1", beat_count, overrun_err); end
    #1 rstn = 1'b0; #1;
    vec++; if ({gnt, busy, beat_count, overrun_err, rsp_valid} !== 12'b0 || rsp_data !== 32'h0) begin errs++;
      $display("FAIL rm_reset: gnt/busy/beats/ovr/valid/data got %b/%b/%0d/%b/%b/%h want zeros",
               gnt, busy, beat_count, overrun_err, rsp_valid, rsp_data); end
    idle_inputs(); cyc(); rstn = 1'b1; cyc();
    m_rr = 0; m_ovr = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]  mask, rdm, wrm;
    logic [23:0] addrs;
    logic [31:0] d;
    logic        extra;
    int          w, nb, given, total, wait_c;
    for (int t = 0; t < 40; t++) begin
      mask = 3'($urandom_range(1, 7)); rdm = 3'($urandom); wrm = 3'($urandom); addrs = 24'($urandom);
      w = pick_model(mask, m_rr);
      req = mask; req_rd = rdm; req_addr = addrs; req_is_write = wrm;
      cyc();
      vec++; if (gnt !== 3'(1 << w) || addr_out !== addrs[w*8 +: 8] || is_write !== wrm[w]) begin errs++;
        $display("FAIL rnd_grant t%0d: gnt/addr/wr got %b/%h/%b want %b/%h/%b",
                 t, gnt, addr_out, is_write, 3'(1 << w), addrs[w*8 +: 8], wrm[w]); end
      wait_c = $urandom_range(0, 2);
      for (int i = 0; i < wait_c; i++) cyc();
      write_complete = 1'b1; #1;
      vec++; if (rsp_write_complete !== 3'(1 << w)) begin errs++;
        $display("FAIL rnd_wc t%0d: got %b want %b", t, rsp_write_complete, 3'(1 << w)); end
      cyc(); write_complete = 1'b0;
      if (rdm[w]) begin
        vec++; if (addr_out !== 8'h00 || is_write !== 1'b0) begin errs++;
          $display("FAIL rnd_addr_rd t%0d: addr/wr got %h/%b want 00/0", t, addr_out, is_write); end
        nb = $urandom_range(0, 10); given = 0;
        while (given < nb) begin
          data_input_ready = 1'($urandom); d = $urandom; data_in = d;
          if (data_input_ready) given++;
          #1;
          vec++; if (rsp_data !== d || rsp_valid !== (data_input_ready ? 3'(1 << w) : 3'b000)) begin errs++;
            $display("FAIL rnd_beat t%0d: data/valid got %h/%b want %h/%b", t, rsp_data, rsp_valid, d,
                     data_input_ready ? 3'(1 << w) : 3'b000); end
          cyc();
        end
        extra = 1'($urandom); data_input_ready = extra; input_data_transfer_complete = 1'b1; #1;
        vec++; if (rsp_done !== 3'(1 << w)) begin errs++;
          $display("FAIL rnd_done t%0d: got %b want %b", t, rsp_done, 3'(1 << w)); end
        cyc(); idle_inputs();
        total = nb + int'(extra);
        if (total > 8) m_ovr = 1'b1;
        vec++; if (beat_count !== 4'((total > 8) ? 8 : total) || overrun_err !== m_ovr) begin errs++;
          $display("FAIL rnd_count t%0d: beats/ovr got %0d/%b want %0d/%b", t, beat_count, overrun_err,
                   (total > 8) ? 8 : total, m_ovr); end
      end else begin
        idle_inputs();
      end
      vec++; if (gnt !== 3'b000 || busy !== 1'b1) begin errs++;
        $display("FAIL rnd_release t%0d: gnt/busy got %b/%b want 000/1", t, gnt, busy); end
      cyc();
      vec++; if (busy !== 1'b0 || beat_count !== 4'd0) begin errs++;
        $display("FAIL rnd_idle t%0d: busy/beats got %b/%0d want 0/0", t, busy, beat_count); end
      m_rr = (w + 1) % 3;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_write_only();
    test_hash_read();
    test_contention();
    test_overrun();
    test_isolation_abort();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
